disp_arbiter: RTL and testbench
===============================

Name: disp_arbiter

Overview:
- Shares the single 4-digit seven-segment display driver between N requesters: up to N producers compete for the display, and one stream of hexs/points/les reaches the display driver.
- Round-robin arbitration with a guaranteed minimum ownership time. A blanking gap separates owner changes so digits never show a mix of two owners' values.
- Sits between client logic (counters, debug taps, ALU result views) and the display driver instance. Its hexs/points/les outputs connect directly to the driver inputs.

Parameters:
- N, 4, number of requesters (2..8).
- IDXW, 2, owner index width; must be at least clog2(N).
- HOLD_CYCLES, 50000000, minimum clk cycles an owner keeps the display once granted (>=1).
- BLANK_CYCLES, 1000000, clk cycles the display is blanked between owners (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req  in  N  request per client; level-sensitive, held while the client wants the display
- hexs_in  in  16*N  client i digits at [16i+15:16i]; [15:12] is the leftmost digit
- points_in  in  4*N  client i decimal points at [4i+3:4i]; 1 = lit
- les_in  in  4*N  client i digit enables at [4i+3:4i]; 0 = digit enabled
- gnt  out  N  one-hot grant; all zero when no owner
- owner  out  IDXW  index of current or last owner
- busy  out  1  high in SHOW and BLANK
- hexs  out  16  to display driver
- points  out  4  to display driver
- les  out  4  to display driver; 4'hF = all digits blank

Behaviour:
- All outputs registered. rst is sampled only on the clk rising edge; rst=0 forces the following in the same edge:
  - state=IDLE, gnt=0, owner=0, rr pointer=0, busy=0
  - hexs=16'h0, points=4'h0, les=4'hF, counters=0
- Reset mid-operation drops any grant immediately; there is no blank gap.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - gnt=0, les=4'hF.
  - If req!=0 at an edge: pick the first requester at or after rr pointer (wrapping N-1 to 0).
  - Same edge: gnt[k]=1, owner=k, hold counter=HOLD_CYCLES-1, state=SHOW.
- SHOW:
  - Every edge: hexs/points/les <= owner's slice of hexs_in/points_in/les_in. Display data therefore lags gnt by 1 cycle, and the owner may change content freely while holding.
  - Hold counter decrements to 0 and saturates there.
  - Owner drops req (any counter value): next edge gnt=0, les=4'hF, blank counter=BLANK_CYCLES-1, rr pointer=owner+1 mod N, state=BLANK.
  - Counter==0 and another requester has req=1: same transition to BLANK.
  - Counter==0 and only the owner requests: stay in SHOW indefinitely. There is no re-blank.
  - Owner drop and expiry in the same cycle: drop takes priority; the result is identical.
- BLANK:
  - gnt=0, les=4'hF, hexs/points hold their last values, busy=1.
  - Counter decrements; at 0 the next edge goes to IDLE.
  - Requests are not granted during BLANK, even a new one.
- Worst-case latency from idle req to first owner data at the driver: 2 edges (gnt, then data).
- Fairness: every requester holding req is granted within N*(HOLD_CYCLES+BLANK_CYCLES+1) cycles.
- gnt is always one-hot or zero.
- Indices wrap: owner+1 mod N wraps N-1 to 0.
- req bits for clients with no data connected are treated normally; tie them to 0.

Test Plan:
(bench params: N=4, HOLD_CYCLES=4, BLANK_CYCLES=2)
- Reset: rst=0 for 2 edges with req=4'hF -> gnt=0, les=4'hF, hexs=0, busy=0; with rst=1, next edge gives gnt=4'b0001.
- Single client: req=4'b0100, hexs_in client 2 = 16'h1234 -> gnt=4'b0100 at edge 1, hexs=16'h1234 at edge 2. Stays granted for 20+ cycles with no blank.
- Contention: req=4'b0011 constant -> client0 SHOW ≥4 cycles, BLANK 2 cycles with les=F, IDLE 1 cycle, then client1 granted. Grants alternate 0,1,0,1 thereafter.
- Early release: client 3 granted, drops req on cycle 2 of hold -> next edge gnt=0, les=4'hF; after 2 BLANK cycles and IDLE, waiting client 0 is granted. rr pointer wrapped 3 to 0.
- Live update: owner changes hexs_in 16'hABCD to 16'hABCE mid-hold -> hexs follows 1 cycle later with gnt unchanged.
- Mid-operation reset: rst=0 during SHOW -> next edge gnt=0, les=4'hF, owner=0. With req=4'b1001 still high, client 0 is granted first after reset releases.

Source files
------------

// File: rtl/disp_arbiter.sv
// Round-robin arbiter that shares one 4-digit seven-segment driver between N clients.
// Owners keep the display for a minimum hold time and owner changes are separated by a blanking gap.
module disp_arbiter #(
    parameter int N            = 4,
    parameter int IDXW         = 2,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLANK_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [16*N-1:0]   hexs_in,
    input  logic [4*N-1:0]    points_in,
    input  logic [4*N-1:0]    les_in,
    output logic [N-1:0]      gnt,
    output logic [IDXW-1:0]   owner,
    output logic              busy,
    output logic [15:0]       hexs,
    output logic [3:0]        points,
    output logic [3:0]        les
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [BW-1:0]     blank_q, blank_d;
    logic              busy_q, busy_d;
    logic [15:0]       hexs_q, hexs_d;
    logic [3:0]        points_q, points_d;
    logic [3:0]        les_q, les_d;

    logic [15:0]       hex_slices   [N];
    logic [3:0]        point_slices [N];
    logic [3:0]        le_slices    [N];

    logic [N-1:0]      upper_mask;
    logic [N-1:0]      upper_req;
    logic [IDXW-1:0]   pick;
    logic              pick_valid;
    logic              owner_req;
    logic              other_req;
    logic [IDXW-1:0]   rr_next;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            hex_slices[i]   = hexs_in[16*i +: 16];
            point_slices[i] = points_in[4*i +: 4];
            le_slices[i]    = les_in[4*i +: 4];
        end
    end

    // Requests at or above the pointer win first; otherwise wrap to the lowest request overall.
    always_comb begin
        upper_mask = ~((N'(1) << rr_q) - N'(1));
        upper_req  = req & upper_mask;
        pick       = '0;
        pick_valid = |req;
        if (|upper_req) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (upper_req[i]) pick = IDXW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) pick = IDXW'(i);
            end
        end
    end

    assign owner_req = |(req & gnt_q);
    assign other_req = |(req & ~gnt_q);
    assign rr_next   = (owner_q == IDXW'(N - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        hold_d   = hold_q;
        blank_d  = blank_q;
        hexs_d   = hexs_q;
        points_d = points_q;
        les_d    = les_q;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                les_d = 4'hF;
                if (pick_valid) begin
                    gnt_d   = N'(1) << pick;
                    owner_d = pick;
                    hold_d  = HOLD_INIT;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                hexs_d   = hex_slices[owner_q];
                points_d = point_slices[owner_q];
                les_d    = le_slices[owner_q];
                if (hold_q != '0) hold_d = hold_q - 1'b1;
                // A release by the owner wins over hold expiry; both lead to the same blank gap.
                if (!owner_req || ((hold_q == '0) && other_req)) begin
                    gnt_d   = '0;
                    les_d   = 4'hF;
                    blank_d = BLANK_INIT;
                    rr_d    = rr_next;
                    state_d = BLANK;
                end
            end
            BLANK: begin
                gnt_d = '0;
                les_d = 4'hF;
                if (blank_q == '0) state_d = IDLE;
                else               blank_d = blank_q - 1'b1;
            end
            default: begin
                gnt_d   = '0;
                les_d   = 4'hF;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
            hold_q   <= '0;
            blank_q  <= '0;
            busy_q   <= 1'b0;
            hexs_q   <= 16'h0;
            points_q <= 4'h0;
            les_q    <= 4'hF;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            hold_q   <= hold_d;
            blank_q  <= blank_d;
            busy_q   <= busy_d;
            hexs_q   <= hexs_d;
            points_q <= points_d;
            les_q    <= les_d;
        end
    end

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign busy   = busy_q;
    assign hexs   = hexs_q;
    assign points = points_q;
    assign les    = les_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter: stimulus queues cycle-tagged expectations, a monitor pops and compares them.
module tb_disp_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [16*N-1:0] hexs_in;
    logic [4*N-1:0] points_in;
    logic [4*N-1:0] les_in;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic [15:0]    hexs;
    logic [3:0]     points;
    logic [3:0]     les;

    int edge_count = 0;
    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  gnt;
        logic [3:0]  les;
        logic        busy;
        logic [1:0]  owner;
        bit          chk_owner;
        logic [15:0] hexs;
        bit          chk_hexs;
        logic [3:0]  points;
        bit          chk_points;
    } exp_t;

    exp_t exp_q[$];

    disp_arbiter #(
        .N(N), .IDXW(2), .HOLD_CYCLES(4), .BLANK_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .hexs_in(hexs_in), .points_in(points_in), .les_in(les_in),
        .gnt(gnt), .owner(owner), .busy(busy),
        .hexs(hexs), .points(points), .les(les)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic compare(input string nm, input logic [15:0] act, input logic [15:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%h required=%h (edge %0d)", nm, act, want, edge_count);
        end
    endtask

    // Monitor: compares every expectation tagged with the edge that just happened.
    always begin
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].cyc <= edge_count) begin
            e = exp_q.pop_front();
            if (e.cyc < edge_count) begin
                compare({e.name, ".stale"}, 16'(edge_count), 16'(e.cyc));
            end else begin
                compare({e.name, ".gnt"},  16'(gnt),  16'(e.gnt));
                compare({e.name, ".les"},  16'(les),  16'(e.les));
                compare({e.name, ".busy"}, 16'(busy), 16'(e.busy));
                if (e.chk_owner)  compare({e.name, ".owner"},  16'(owner),  16'(e.owner));
                if (e.chk_hexs)   compare({e.name, ".hexs"},   hexs,        e.hexs);
                if (e.chk_points) compare({e.name, ".points"}, 16'(points), 16'(e.points));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
    endtask

    task automatic set_client(input int i, input logic [15:0] h, input logic [3:0] p);
        hexs_in[16*i +: 16] = h;
        points_in[4*i +: 4] = p;
        les_in[4*i +: 4]    = 4'h0;
    endtask

    // Queues the expected outputs after edge (current + off).
    task automatic checkOutput(input int off, input string nm,
                               input logic [3:0] g, input logic [3:0] l, input logic b,
                               input bit co, input logic [1:0] o,
                               input bit ch, input logic [15:0] h,
                               input bit cp, input logic [3:0] p);
        exp_t e;
        e.cyc = edge_count + off;
        e.name = nm;
        e.gnt = g; e.les = l; e.busy = b;
        e.chk_owner = co; e.owner = o;
        e.chk_hexs = ch; e.hexs = h;
        e.chk_points = cp; e.points = p;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 4'h0);
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        hexs_in = '0;
        points_in = '0;
        les_in = '0;
        set_client(0, 16'h00C0, 4'h0);
        set_client(1, 16'h11C1, 4'h1);
        set_client(2, 16'h1234, 4'h2);
        set_client(3, 16'h33C3, 4'h3);
        step(1);

        $display("[TB] reset with all clients requesting");
        applyStimulus(1'b0, 4'hF);
        checkOutput(1, "rst_a", 4'b0000, 4'hF, 1'b0, 1, 2'd0, 1, 16'h0, 1, 4'h0);
        checkOutput(2, "rst_b", 4'b0000, 4'hF, 1'b0, 1, 2'd0, 1, 16'h0, 1, 4'h0);
        step(2);
        rst = 1'b1;
        checkOutput(1, "rst_rel_gnt",  4'b0001, 4'hF, 1'b1, 1, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(2, "rst_rel_data", 4'b0001, 4'h0, 1'b1, 1, 2'd0, 1, 16'h00C0, 0, 4'h0);
        step(2);

        $display("[TB] single client keeps the display");
        do_reset();
        req = 4'b0100;
        checkOutput(1,  "single_gnt",  4'b0100, 4'hF, 1'b1, 1, 2'd2, 0, 16'h0, 0, 4'h0);
        checkOutput(2,  "single_data", 4'b0100, 4'h0, 1'b1, 1, 2'd2, 1, 16'h1234, 1, 4'h2);
        checkOutput(10, "single_mid",  4'b0100, 4'h0, 1'b1, 0, 2'd0, 1, 16'h1234, 0, 4'h0);
        checkOutput(22, "single_hold", 4'b0100, 4'h0, 1'b1, 1, 2'd2, 1, 16'h1234, 1, 4'h2);
        step(22);

        $display("[TB] two clients contend");
        do_reset();
        req = 4'b0011;
        checkOutput(1,  "cont_g0",     4'b0001, 4'hF, 1'b1, 1, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(4,  "cont_show0",  4'b0001, 4'h0, 1'b1, 0, 2'd0, 1, 16'h00C0, 0, 4'h0);
        checkOutput(5,  "cont_blank1", 4'b0000, 4'hF, 1'b1, 0, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(6,  "cont_blank2", 4'b0000, 4'hF, 1'b1, 0, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(7,  "cont_idle",   4'b0000, 4'hF, 1'b0, 0, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(8,  "cont_g1",     4'b0010, 4'hF, 1'b1, 1, 2'd1, 0, 16'h0, 0, 4'h0);
        checkOutput(9,  "cont_show1",  4'b0010, 4'h0, 1'b1, 1, 2'd1, 1, 16'h11C1, 1, 4'h1);
        checkOutput(15, "cont_g0_again", 4'b0001, 4'hF, 1'b1, 1, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(22, "cont_g1_again", 4'b0010, 4'hF, 1'b1, 1, 2'd1, 0, 16'h0, 0, 4'h0);
        step(23);

        $display("[TB] early release and pointer wrap");
        do_reset();
        req = 4'b1000;
        checkOutput(1, "early_g3",   4'b1000, 4'hF, 1'b1, 1, 2'd3, 0, 16'h0, 0, 4'h0);
        checkOutput(2, "early_data", 4'b1000, 4'h0, 1'b1, 1, 2'd3, 1, 16'h33C3, 1, 4'h3);
        step(2);
        req = 4'b0101;
        checkOutput(1, "early_blank1", 4'b0000, 4'hF, 1'b1, 0, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(2, "early_blank2", 4'b0000, 4'hF, 1'b1, 0, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(3, "early_idle",   4'b0000, 4'hF, 1'b0, 0, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(4, "early_wrap_g0", 4'b0001, 4'hF, 1'b1, 1, 2'd0, 0, 16'h0, 0, 4'h0);
        step(5);

        $display("[TB] live update while holding");
        do_reset();
        set_client(1, 16'hABCD, 4'h1);
        req = 4'b0010;
        checkOutput(1, "live_gnt",  4'b0010, 4'hF, 1'b1, 1, 2'd1, 0, 16'h0, 0, 4'h0);
        checkOutput(2, "live_old",  4'b0010, 4'h0, 1'b1, 1, 2'd1, 1, 16'hABCD, 0, 4'h0);
        step(2);
        set_client(1, 16'hABCE, 4'h1);
        checkOutput(1, "live_new",  4'b0010, 4'h0, 1'b1, 1, 2'd1, 1, 16'hABCE, 0, 4'h0);
        step(2);
        set_client(1, 16'h11C1, 4'h1);

        $display("[TB] reset while showing");
        do_reset();
        req = 4'b1000;
        checkOutput(2, "midrst_show", 4'b1000, 4'h0, 1'b1, 1, 2'd3, 1, 16'h33C3, 0, 4'h0);
        step(2);
        applyStimulus(1'b0, 4'b1001);
        checkOutput(1, "midrst_clear", 4'b0000, 4'hF, 1'b0, 1, 2'd0, 1, 16'h0, 1, 4'h0);
        step(1);
        rst = 1'b1;
        checkOutput(1, "midrst_g0",   4'b0001, 4'hF, 1'b1, 1, 2'd0, 0, 16'h0, 0, 4'h0);
        checkOutput(2, "midrst_data", 4'b0001, 4'h0, 1'b1, 1, 2'd0, 1, 16'h00C0, 0, 4'h0);
        step(3);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
